// File: rtl/fns_enc_seq20_pkg.sv
// Shared FNS constants, weight table and encoder state encodings for the 20-wire Fibonacci CAC link.
package fns_enc_seq20_pkg;

  localparam int unsigned NBITS   = 20;
  localparam int unsigned FBLEN20 = 15;
  localparam int unsigned DW      = FBLEN20;
  localparam int unsigned IDXW    = 5;

  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NBITS - 1);

  localparam logic [DW-1:0] FNS01 = 15'd1;
  localparam logic [DW-1:0] FNS02 = 15'd2;
  localparam logic [DW-1:0] FNS03 = 15'd3;
  localparam logic [DW-1:0] FNS04 = 15'd5;
  localparam logic [DW-1:0] FNS05 = 15'd8;
  localparam logic [DW-1:0] FNS06 = 15'd13;
  localparam logic [DW-1:0] FNS07 = 15'd21;
  localparam logic [DW-1:0] FNS08 = 15'd34;
  localparam logic [DW-1:0] FNS09 = 15'd55;
  localparam logic [DW-1:0] FNS10 = 15'd89;
  localparam logic [DW-1:0] FNS11 = 15'd144;
  localparam logic [DW-1:0] FNS12 = 15'd233;
  localparam logic [DW-1:0] FNS13 = 15'd377;
  localparam logic [DW-1:0] FNS14 = 15'd610;
  localparam logic [DW-1:0] FNS15 = 15'd987;
  localparam logic [DW-1:0] FNS16 = 15'd1597;
  localparam logic [DW-1:0] FNS17 = 15'd2584;
  localparam logic [DW-1:0] FNS18 = 15'd4181;
  localparam logic [DW-1:0] FNS19 = 15'd6765;
  localparam logic [DW-1:0] FNS20 = 15'd10946;

  // Largest value representable in 20 non-adjacent Fibonacci digits.
  localparam logic [DW-1:0]    FNS_MAX      = 15'd17710;
  localparam logic [NBITS-1:0] FNS_SAT_CODE = 20'hAAAAA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/fns_enc_seq20_weight_sel20.sv
// Combinational bit-index to FNS weight mux (index k selects weight w(k+1)).
module fns_weight_sel20
  import fns_enc_seq20_pkg::*;
(
  input  logic [IDXW-1:0] idx,
  output logic [DW-1:0]   weight_c
);

  always_comb begin
    weight_c = '0;
    case (idx)
      5'd0:    weight_c = FNS01;
      5'd1:    weight_c = FNS02;
      5'd2:    weight_c = FNS03;
      5'd3:    weight_c = FNS04;
      5'd4:    weight_c = FNS05;
      5'd5:    weight_c = FNS06;
      5'd6:    weight_c = FNS07;
      5'd7:    weight_c = FNS08;
      5'd8:    weight_c = FNS09;
      5'd9:    weight_c = FNS10;
      5'd10:   weight_c = FNS11;
      5'd11:   weight_c = FNS12;
      5'd12:   weight_c = FNS13;
      5'd13:   weight_c = FNS14;
      5'd14:   weight_c = FNS15;
      5'd15:   weight_c = FNS16;
      5'd16:   weight_c = FNS17;
      5'd17:   weight_c = FNS18;
      5'd18:   weight_c = FNS19;
      5'd19:   weight_c = FNS20;
      default: weight_c = '0;
    endcase
  end

endmodule

// File: rtl/fns_enc_seq20.sv
// Sequential greedy binary-to-FNS encoder, one codeword bit per clock, MSB first.
// Optional range check and saturation enabled by defining FNS_ENC_RANGE_CHK_EN.
module fns_enc_seq20
  import fns_enc_seq20_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NBITS-1:0] code_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  enc_state_e       state_q, state_d;
  logic [DW-1:0]    rem_q, rem_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [NBITS-1:0] code_q, code_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             err_q, err_d;
  logic [DW-1:0]    weight_c;

  fns_weight_sel20 u_weight_sel (
    .idx      (idx_q),
    .weight_c (weight_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      idx_q       <= IDX_MSB;
      code_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      code_q      <= code_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    code_d      = code_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rem_d   = in_data;
          idx_d   = IDX_MSB;
          code_d  = '0;
          state_d = ST_ENC;
`ifdef FNS_ENC_RANGE_CHK_EN
          err_d   = (in_data > FNS_MAX);
`else
          err_d   = 1'b0;
`endif
        end
      end

      ST_ENC: begin
        // Guarded subtract: the compare keeps the remainder from underflowing.
        if (rem_q >= weight_c) begin
          code_d[idx_q] = 1'b1;
          rem_d         = rem_q - weight_c;
        end
        if (idx_q == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
`ifdef FNS_ENC_RANGE_CHK_EN
          if (err_q) code_d = FNS_SAT_CODE;
`endif
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign code_out  = code_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule
